// File: rtl/conv_frame_sink.sv
// Frame sink for the 3x3 conv output stream: rebuilds the raster frame in an
// internal buffer, tracks pixel position and holds the finished frame for readback.
module conv_frame_sink #(
  parameter int IMG_W = 218,
  parameter int IMG_H = 218,
  parameter int DW    = 8,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] pxl_in,
  input  logic          valid,
  input  logic          frame_ack,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [15:0]   col,
  output logic [15:0]   row,
  output logic          eol,
  output logic          eof,
  output logic          frame_done,
  output logic          ovf,
  output logic [AW-1:0] pxl_count
);

  localparam logic [AW-1:0] DEPTH    = AW'(IMG_W * IMG_H);
  localparam logic [15:0]   LAST_COL = 16'(IMG_W - 1);
  localparam logic [15:0]   LAST_ROW = 16'(IMG_H - 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] DONE = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [15:0]   nxt_col;
  logic [15:0]   nxt_row;
  logic          accept;
  logic          last_pxl;

  // Address space covers the full AW range so any rd_addr indexes safely.
  logic [DW-1:0] mem [0:(2**AW)-1];

  assign accept    = (state == FILL) && valid;
  assign last_pxl  = (nxt_col == LAST_COL) && (nxt_row == LAST_ROW);
  assign pxl_count = wr_ptr;

  // nxt_col/nxt_row point at the position the next accepted pixel will take.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      wr_ptr     <= '0;
      nxt_col    <= '0;
      nxt_row    <= '0;
      col        <= '0;
      row        <= '0;
      eol        <= 1'b0;
      eof        <= 1'b0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      eol <= 1'b0;
      eof <= 1'b0;
      if (state == FILL) begin
        if (valid) begin
          wr_ptr <= wr_ptr + 1'b1;
          col    <= nxt_col;
          row    <= nxt_row;
          if (nxt_col == LAST_COL) begin
            nxt_col <= '0;
            nxt_row <= nxt_row + 16'd1;
            eol     <= 1'b1;
          end else begin
            nxt_col <= nxt_col + 16'd1;
          end
          if (last_pxl) begin
            eof        <= 1'b1;
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
      end else begin
        if (valid) begin
          ovf <= 1'b1;
        end
        if (frame_ack) begin
          state      <= FILL;
          frame_done <= 1'b0;
          wr_ptr     <= '0;
          nxt_col    <= '0;
          nxt_row    <= '0;
          col        <= '0;
          row        <= '0;
        end
      end
    end
  end

  // Buffer is intentionally never cleared so stale frames stay readable.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      mem[wr_ptr] <= pxl_in;
    end
  end

  // Registered read sees pre-write contents when addresses collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= (rd_addr < DEPTH) ? mem[rd_addr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_sink.sv
// Self-checking bench for conv_frame_sink: a 4x3 instance against a counting
// reference model, plus a default 218x218 instance streamed with a ramp.
module tb_conv_frame_sink;

  localparam int W = 4;
  localparam int H = 3;
  localparam int BIG_W = 218;
  localparam int BIG_H = 218;
  localparam int BIG_N = BIG_W * BIG_H;

  logic        clk;
  logic        reset;
  logic [7:0]  pxl_in;
  logic        valid;
  logic        frame_ack;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [15:0] col;
  logic [15:0] row;
  logic        eol;
  logic        eof;
  logic        frame_done;
  logic        ovf;
  logic [15:0] pxl_count;

  logic [7:0]  b_pxl_in;
  logic        b_valid;
  logic        b_frame_ack;
  logic        b_rd_en;
  logic [15:0] b_rd_addr;
  logic [7:0]  b_rd_data;
  logic        b_rd_valid;
  logic [15:0] b_col;
  logic [15:0] b_row;
  logic        b_eol;
  logic        b_eof;
  logic        b_frame_done;
  logic        b_ovf;
  logic [15:0] b_pxl_count;

  int checks = 0;
  int passes = 0;

  logic [7:0] m_mem [W*H];
  int         m_count;
  int         m_col;
  int         m_row;
  bit         m_eol;
  bit         m_eof;
  bit         m_done;
  bit         m_ovf;
  bit         m_rd_valid;
  logic [7:0] m_rd_data;

  conv_frame_sink #(.IMG_W(W), .IMG_H(H), .DW(8), .AW(16)) dut (
    .clk(clk), .reset(reset), .pxl_in(pxl_in), .valid(valid),
    .frame_ack(frame_ack), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .col(col), .row(row),
    .eol(eol), .eof(eof), .frame_done(frame_done), .ovf(ovf),
    .pxl_count(pxl_count)
  );

  conv_frame_sink dut_big (
    .clk(clk), .reset(reset), .pxl_in(b_pxl_in), .valid(b_valid),
    .frame_ack(b_frame_ack), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .col(b_col), .row(b_row),
    .eol(b_eol), .eof(b_eof), .frame_done(b_frame_done), .ovf(b_ovf),
    .pxl_count(b_pxl_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_output();
    check("col", 32'(col), m_col);
    check("row", 32'(row), m_row);
    check("eol", 32'(eol), 32'(m_eol));
    check("eof", 32'(eof), 32'(m_eof));
    check("frame_done", 32'(frame_done), 32'(m_done));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("pxl_count", 32'(pxl_count), m_count);
    check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
    check("rd_data", 32'(rd_data), 32'(m_rd_data));
  endtask

  // One clock of stimulus; the model follows the behavioural rules in terms of
  // how many pixels the current frame has taken.
  task automatic apply_stimulus(input bit v, input logic [7:0] pix, input bit ack,
                                input bit ren, input int raddr);
    valid = v; pxl_in = pix; frame_ack = ack; rd_en = ren; rd_addr = 16'(raddr);
    m_eol = 0;
    m_eof = 0;
    m_rd_valid = ren;
    if (ren) begin
      if (raddr < W*H) m_rd_data = m_mem[raddr];
      else m_rd_data = 8'h00;
    end
    if (!m_done) begin
      if (v) begin
        m_mem[m_count] = pix;
        m_count++;
        m_col  = (m_count - 1) % W;
        m_row  = (m_count - 1) / W;
        m_eol  = (m_col == W - 1);
        m_eof  = (m_count == W * H);
        m_done = m_eof;
      end
    end else begin
      if (v) m_ovf = 1;
      if (ack) begin
        m_done = 0; m_count = 0; m_col = 0; m_row = 0;
      end
    end
    @(posedge clk); #1;
    valid = 0; frame_ack = 0; rd_en = 0;
    check_output();
  endtask

  task automatic do_reset();
    reset = 1; valid = 0; frame_ack = 0; rd_en = 0;
    @(posedge clk); #1;
    reset = 0;
    m_count = 0; m_col = 0; m_row = 0; m_eol = 0; m_eof = 0;
    m_done = 0; m_ovf = 0; m_rd_valid = 0; m_rd_data = 8'h00;
    check_output();
  endtask

  task automatic read_all();
    for (int a = 0; a < W*H; a++) apply_stimulus(0, 8'h00, 0, 1, a);
  endtask

  initial begin
    int eof_cnt;
    int eol_cnt;
    int iter;
    reset = 0; pxl_in = 0; valid = 0; frame_ack = 0; rd_en = 0; rd_addr = 0;
    b_pxl_in = 0; b_valid = 0; b_frame_ack = 0; b_rd_en = 0; b_rd_addr = 0;
    @(posedge clk); #1;
    do_reset();

    $display("[TB] full frame of consecutive pixels");
    for (int i = 0; i < 12; i++) apply_stimulus(1, 8'(i), 0, 0, 0);
    read_all();
    apply_stimulus(0, 8'h00, 0, 0, 0);

    $display("[TB] overflow while frame held");
    apply_stimulus(1, 8'hFF, 0, 0, 0);
    apply_stimulus(1, 8'hFF, 0, 1, 0);
    check("ovf_mem0", 32'(rd_data), 32'h00);
    apply_stimulus(0, 8'h00, 1, 0, 0);

    $display("[TB] gapped valid stream");
    for (int i = 0; i < 24; i++) apply_stimulus(i % 2 == 0, 8'(i / 2), 0, 0, 0);
    read_all();

    $display("[TB] second frame after ack");
    apply_stimulus(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 12; i++) apply_stimulus(1, 8'(8'h80 + i), 0, 0, 0);
    apply_stimulus(0, 8'h00, 0, 1, 5);
    check("frame2_addr5", 32'(rd_data), 32'h85);

    $display("[TB] reset mid-frame");
    apply_stimulus(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 6; i++) apply_stimulus(1, 8'(8'hA0 + i), 0, 0, 0);
    do_reset();
    for (int i = 0; i < 12; i++) apply_stimulus(1, 8'(8'h40 + i), 0, 0, 0);
    apply_stimulus(0, 8'h00, 0, 1, 0);
    check("restart_addr0", 32'(rd_data), 32'h40);
    apply_stimulus(0, 8'h00, 0, 1, 12);
    check("oob_data", 32'(rd_data), 32'h00);
    check("oob_valid", 32'(rd_valid), 32'h1);

    $display("[TB] ack and valid together, then random frame");
    apply_stimulus(1, 8'h55, 1, 0, 0);
    iter = 0;
    while (!m_done && iter < 300) begin
      int raddr;
      raddr = ($urandom % 3 == 0) ? m_count : int'($urandom_range(0, 13));
      apply_stimulus($urandom % 2 == 1, 8'($urandom), ($urandom % 8) == 0,
                     ($urandom % 2) == 1, raddr);
      iter++;
    end
    check("rand_frame_done", 32'(frame_done), 32'h1);
    read_all();

    $display("[TB] default-size ramp frame");
    eof_cnt = 0;
    eol_cnt = 0;
    for (int i = 0; i < BIG_N; i++) begin
      b_valid = 1; b_pxl_in = 8'(i);
      @(posedge clk); #1;
      if (b_eof) eof_cnt++;
      if (b_eol) eol_cnt++;
      if (i == BIG_N - 2) check("big_not_done_early", 32'(b_frame_done), 32'h0);
    end
    b_valid = 0;
    check("big_frame_done", 32'(b_frame_done), 32'h1);
    check("big_pxl_count", 32'(b_pxl_count), BIG_N);
    check("big_eof_count", eof_cnt, 1);
    check("big_eol_count", eol_cnt, BIG_H);
    check("big_last_col", 32'(b_col), BIG_W - 1);
    check("big_last_row", 32'(b_row), BIG_H - 1);
    b_rd_en = 1; b_rd_addr = 16'(BIG_N - 1);
    @(posedge clk); #1;
    b_rd_en = 0;
    check("big_rd_last", 32'(b_rd_data), 32'hA3);
    check("big_rd_valid", 32'(b_rd_valid), 32'h1);
    b_rd_en = 1; b_rd_addr = 16'd300;
    @(posedge clk); #1;
    b_rd_en = 0;
    check("big_rd_300", 32'(b_rd_data), 32'(300 % 256));
    check("big_ovf", 32'(b_ovf), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
